cardiac_therapy_sequencer: RTL and testbench



---
 rtl/cardiac_therapy_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_cardiac_therapy_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cardiac_therapy_sequencer.sv
// CPR / two-stage adenosine sequencer with persistence-filtered rhythm classification.
// Optional WEIGHT_DOSE_EN macro: weight-scaled dosing instead of fixed dose codes.
module cardiac_therapy_sequencer #(
  parameter int DATA_W      = 8,
  parameter int HR_LOW      = 50,
  parameter int HR_HIGH     = 120,
  parameter int PERSIST     = 4,
  parameter int TICK_DIV    = 1000,
  parameter int DOSE_TICKS  = 2,
  parameter int FLUSH_TICKS = 2,
  parameter int WAIT_TICKS  = 120,
  parameter int DOSE1_MG    = 6,
  parameter int DOSE2_MG    = 12,
  parameter int FLUSH_ML    = 20,
  parameter int DOSE_Q4     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] heart_rate,
  input  logic [DATA_W-1:0] patient_weight,
  output logic              cpr_activate,
  output logic              drug_delivery_activate,
  output logic [DATA_W-1:0] drug_dosage,
  output logic              dose_strobe,
  output logic              alarm,
  output logic [2:0]        state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CPR     = 3'd1;
  localparam logic [2:0] S_DOSE1   = 3'd2;
  localparam logic [2:0] S_FLUSH1  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_DOSE2   = 3'd5;
  localparam logic [2:0] S_FLUSH2  = 3'd6;
  localparam logic [2:0] S_LOCKOUT = 3'd7;

  localparam logic [1:0] C_NORM  = 2'd0;
  localparam logic [1:0] C_BRADY = 2'd1;
  localparam logic [1:0] C_TACHY = 2'd2;

  localparam logic [DATA_W-1:0] D1_MG = DATA_W'(DOSE1_MG);
  localparam logic [DATA_W-1:0] D2_MG = DATA_W'(DOSE2_MG);
  localparam logic [DATA_W-1:0] FL_ML = DATA_W'(FLUSH_ML);

  logic [2:0]        state, state_nx;
  logic [1:0]        cls, pcls, conf_cls, last_conf;
  logic [7:0]        pcnt, pcnt_nx;
  logic              confirm, conf_v;
  logic [PW-1:0]     presc;
  logic              tick;
  logic [15:0]       phase_cnt, phase_len;
  logic              phase_done;
  logic [DATA_W-1:0] dose1_cur, dose2_cur, dosage_nx;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cls = C_NORM;
    if (heart_rate < DATA_W'(HR_LOW))       cls = C_BRADY;
    else if (heart_rate > DATA_W'(HR_HIGH)) cls = C_TACHY;

    pcnt_nx = pcnt;
    if (pcnt == 8'd0 || cls != pcls) pcnt_nx = 8'd1;
    else if (pcnt != 8'hFF)          pcnt_nx = pcnt + 8'd1;
  end

  // Asystole confirms at once; otherwise the count must have reached PERSIST.
  assign confirm = sample_valid && (pcnt_nx >= 8'(PERSIST) || heart_rate == '0);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcls      <= C_NORM;
      pcnt      <= 8'd0;
      conf_v    <= 1'b0;
      conf_cls  <= C_NORM;
      last_conf <= C_NORM;
    end else begin
      conf_v <= 1'b0;
      if (sample_valid) begin
        pcls <= cls;
        pcnt <= pcnt_nx;
        if (confirm) begin
          conf_v    <= 1'b1;
          conf_cls  <= cls;
          last_conf <= cls;
        end
      end
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    phase_len = 16'd0;
    case (state)
      S_DOSE1, S_DOSE2:   phase_len = 16'(DOSE_TICKS);
      S_FLUSH1, S_FLUSH2: phase_len = 16'(FLUSH_TICKS);
      S_WAIT:             phase_len = 16'(WAIT_TICKS);
      default:            phase_len = 16'd0;
    endcase
  end

  assign phase_done = tick && (phase_cnt == phase_len - 16'd1);

  always_comb begin
    logic brady_c, tachy_c, norm_c;
    brady_c  = conf_v && conf_cls == C_BRADY;
    tachy_c  = conf_v && conf_cls == C_TACHY;
    norm_c   = conf_v && conf_cls == C_NORM;
    state_nx = state;
    case (state)
      S_IDLE:    if (brady_c) state_nx = S_CPR; else if (tachy_c) state_nx = S_DOSE1;
      S_CPR:     if (conf_v && !brady_c) state_nx = S_IDLE;
      S_DOSE1:   if (brady_c) state_nx = S_CPR; else if (phase_done) state_nx = S_FLUSH1;
      S_FLUSH1:  if (brady_c) state_nx = S_CPR; else if (phase_done) state_nx = S_WAIT;
      S_WAIT: begin
        if (brady_c)         state_nx = S_CPR;
        else if (norm_c)     state_nx = S_IDLE;
        else if (phase_done) state_nx = (last_conf == C_TACHY) ? S_DOSE2 : S_IDLE;
      end
      S_DOSE2:   if (brady_c) state_nx = S_CPR; else if (phase_done) state_nx = S_FLUSH2;
      S_FLUSH2:  if (brady_c) state_nx = S_CPR; else if (phase_done) state_nx = S_LOCKOUT;
      default:   if (brady_c) state_nx = S_CPR; else if (norm_c) state_nx = S_IDLE;
    endcase
  end

`ifdef WEIGHT_DOSE_EN
  logic [2*DATA_W-1:0] dose_prod, dose_scaled;
  logic [DATA_W-1:0]   dose1_calc, dose1_q;
  logic [DATA_W:0]     dose_dbl;

  assign dose_prod   = {{DATA_W{1'b0}}, patient_weight} * (2*DATA_W)'(DOSE_Q4);
  assign dose_scaled = dose_prod >> 4;
  assign dose1_calc  = (dose_scaled == '0) ? DATA_W'(1) :
                       (dose_scaled > (2*DATA_W)'(DOSE1_MG)) ? D1_MG :
                       dose_scaled[DATA_W-1:0];
  // The weight is sampled on the DOSE1 entry edge; the latched dose feeds dose2 later.
  assign dose1_cur   = (state == S_DOSE1) ? dose1_q : dose1_calc;
  assign dose_dbl    = {dose1_q, 1'b0};
  assign dose2_cur   = (dose_dbl > (DATA_W+1)'(DOSE2_MG)) ? D2_MG : dose_dbl[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         dose1_q <= '0;
    else if (state_nx == S_DOSE1 && state != S_DOSE1) dose1_q <= dose1_calc;
  end
`else
  logic unused_weight;
  assign unused_weight = ^patient_weight;
  assign dose1_cur     = D1_MG;
  assign dose2_cur     = D2_MG;
`endif

  always_comb begin
    dosage_nx = '0;
    case (state_nx)
      S_DOSE1:            dosage_nx = dose1_cur;
      S_DOSE2:            dosage_nx = dose2_cur;
      S_FLUSH1, S_FLUSH2: dosage_nx = FL_ML;
      default:            dosage_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= S_IDLE;
      presc                  <= '0;
      phase_cnt              <= 16'd0;
      cpr_activate           <= 1'b0;
      drug_delivery_activate <= 1'b0;
      drug_dosage            <= '0;
      dose_strobe            <= 1'b0;
      alarm                  <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= tick ? '0 : presc + PW'(1);
      if (state_nx != state) phase_cnt <= 16'd0;
      else if (tick)         phase_cnt <= phase_cnt + 16'd1;
      cpr_activate           <= (state_nx == S_CPR);
      drug_delivery_activate <= (state_nx >= S_DOSE1 && state_nx <= S_FLUSH2);
      drug_dosage            <= dosage_nx;
      dose_strobe            <= (state_nx != state) &&
                                (state_nx == S_DOSE1 || state_nx == S_FLUSH1 ||
                                 state_nx == S_DOSE2 || state_nx == S_FLUSH2);
      alarm                  <= (state_nx == S_LOCKOUT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cardiac_therapy_sequencer.sv
// Directed self-checking bench: TICK_DIV=1, PERSIST=3, DOSE=2, FLUSH=3, WAIT=5 ticks.
// Define WEIGHT_DOSE_EN to also exercise weight-scaled dosing.
module tb_cardiac_therapy_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic [7:0] heart_rate;
  logic [7:0] patient_weight;
  logic       cpr_activate;
  logic       drug_delivery_activate;
  logic [7:0] drug_dosage;
  logic       dose_strobe;
  logic       alarm;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  cardiac_therapy_sequencer #(
    .DATA_W(8), .HR_LOW(50), .HR_HIGH(120), .PERSIST(3), .TICK_DIV(1),
    .DOSE_TICKS(2), .FLUSH_TICKS(3), .WAIT_TICKS(5),
    .DOSE1_MG(6), .DOSE2_MG(12), .FLUSH_ML(20), .DOSE_Q4(2)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .heart_rate(heart_rate),
    .patient_weight(patient_weight), .cpr_activate(cpr_activate),
    .drug_delivery_activate(drug_delivery_activate), .drug_dosage(drug_dosage),
    .dose_strobe(dose_strobe), .alarm(alarm), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] hr, input int n);
    sample_valid = 1'b1;
    heart_rate   = hr;
    for (int i = 0; i < n; i++) step();
    sample_valid = 1'b0;
  endtask

  function automatic logic [7:0] exp_dose(input logic [2:0] st);
    case (st)
      3'd2:       return 8'd6;
      3'd5:       return 8'd12;
      3'd3, 3'd6: return 8'd20;
      default:    return 8'd0;
    endcase
  endfunction

  logic [2:0] seq1 [16] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4,
                            3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7};
  int strobes;

  initial begin
    rst            = 1'b1;
    sample_valid   = 1'b0;
    heart_rate     = 8'd80;
    patient_weight = 8'd255;
    #12;
    check("rst_state", state_o, 0);
    check("rst_cpr", cpr_activate, 0);
    check("rst_deliv", drug_delivery_activate, 0);
    check("rst_dose", drug_dosage, 0);
    check("rst_alarm", alarm, 0);
    step();
    rst = 1'b0;

    // Full two-stage sequence with tachycardia held throughout
    sample_valid = 1'b1;
    heart_rate   = 8'd130;
    for (int i = 0; i < 3; i++) step();
    check("tachy_latency_idle", state_o, 0);
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (dose_strobe) strobes++;
      check($sformatf("seq_state[%0d]", i), state_o, seq1[i]);
      check($sformatf("seq_dose[%0d]", i), drug_dosage, exp_dose(seq1[i]));
    end
    check("seq_strobes", strobes, 4);
    check("lock_alarm", alarm, 1);
    check("lock_deliv", drug_delivery_activate, 0);
    step();
    step();
    check("lock_no_restart", state_o, 7);
    sample_valid = 1'b0;
    feed(8'd80, 3);
    step();
    check("lock_exit_state", state_o, 0);
    check("lock_exit_alarm", alarm, 0);

    // Broken runs of tachy never confirm; brady -> CPR; normal -> IDLE
    feed(8'd130, 2);
    feed(8'd80, 1);
    feed(8'd130, 2);
    step();
    step();
    check("broken_state", state_o, 0);
    check("broken_deliv", drug_delivery_activate, 0);
    feed(8'd40, 3);
    step();
    check("brady_state", state_o, 1);
    check("brady_cpr", cpr_activate, 1);
    feed(8'd80, 3);
    step();
    check("cpr_exit_state", state_o, 0);
    check("cpr_exit_cpr", cpr_activate, 0);

    // Asystole during FLUSH1 preempts the running flush
    feed(8'd130, 3);
    step();
    step();
    step();
    check("flush1_state", state_o, 3);
    feed(8'd0, 1);
    step();
    check("asys_state", state_o, 1);
    check("asys_cpr", cpr_activate, 1);
    check("asys_dose", drug_dosage, 0);
    check("asys_deliv", drug_delivery_activate, 0);
    feed(8'd80, 3);
    step();
    check("asys_exit", state_o, 0);

    // Normal rhythm confirmed during WAIT aborts before DOSE2
    feed(8'd130, 3);
    step();
    for (int i = 0; i < 5; i++) step();
    check("wait_state", state_o, 4);
    check("wait_deliv", drug_delivery_activate, 1);
    check("wait_dose", drug_dosage, 0);
    feed(8'd90, 3);
    step();
    check("wait_abort_state", state_o, 0);
    check("wait_abort_deliv", drug_delivery_activate, 0);
    for (int i = 0; i < 3; i++) step();
    check("wait_no_dose2", state_o, 0);

    // Asynchronous reset in DOSE2, then persistence restarts from zero
    feed(8'd130, 3);
    step();
    for (int i = 0; i < 10; i++) step();
    check("dose2_state", state_o, 5);
    check("dose2_dose", drug_dosage, 12);
    rst = 1'b1;
    #1;
    check("arst_state", state_o, 0);
    check("arst_dose", drug_dosage, 0);
    check("arst_deliv", drug_delivery_activate, 0);
    step();
    rst = 1'b0;
    feed(8'd130, 2);
    step();
    step();
    check("post_rst_two", state_o, 0);
    feed(8'd130, 1);
    step();
    check("post_rst_third", state_o, 2);
    check("post_rst_strobe", dose_strobe, 1);

`ifdef WEIGHT_DOSE_EN
    // weight 20 kg: (20*2)>>4 = 2 mg, second dose 4 mg
    rst = 1'b1;
    step();
    rst = 1'b0;
    patient_weight = 8'd20;
    feed(8'd130, 3);
    step();
    check("wt_dose1", drug_dosage, 2);
    for (int i = 0; i < 10; i++) step();
    check("wt_dose2_state", state_o, 5);
    check("wt_dose2", drug_dosage, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
